// File: rtl/main_fsm.sv
// Multicycle RISC-V control FSM: sequences fetch/decode/execute/writeback
// and drives the datapath mux selects and write strobes from the current state.
module main_fsm (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic       Zero,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic       AdrSrc,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       PCUpdate,
  output logic       Branch,
  output logic       PCWrite,
  output logic [1:0] ALUOp,
  output logic [3:0] state
);

  localparam int unsigned CTRL_W = 14;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_RTYP = 7'b0110011;
  localparam logic [6:0] OP_ITYP = 7'b0010011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECI    = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10
  } state_t;

  state_t            state_q;
  logic [CTRL_W-1:0] ctrl_q;
  logic [CTRL_W-1:0] ctrl;
  logic              state_legal;

  // Successor state; any unused encoding falls back to Fetch.
  function automatic state_t next_state(input state_t s, input logic [6:0] opc);
    state_t n;
    n = S_FETCH;
    case (s)
      S_FETCH:  n = S_DECODE;
      S_DECODE: begin
        case (opc)
          OP_LW, OP_SW: n = S_MEMADR;
          OP_RTYP:      n = S_EXECR;
          OP_ITYP:      n = S_EXECI;
          OP_JAL:       n = S_JAL;
          OP_BEQ:       n = S_BEQ;
          default:      n = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        if (opc == OP_LW)      n = S_MEMREAD;
        else if (opc == OP_SW) n = S_MEMWRITE;
        else                   n = S_FETCH;
      end
      S_MEMREAD:  n = S_MEMWB;
      S_MEMWB:    n = S_FETCH;
      S_MEMWRITE: n = S_FETCH;
      S_EXECR:    n = S_ALUWB;
      S_EXECI:    n = S_ALUWB;
      S_JAL:      n = S_ALUWB;
      S_ALUWB:    n = S_FETCH;
      S_BEQ:      n = S_FETCH;
      default:    n = S_FETCH;
    endcase
    return n;
  endfunction

  // Moore output table, packed as {ALUSrcA,ALUSrcB,ResultSrc,AdrSrc,IRWrite,
  // RegWrite,MemWrite,PCUpdate,Branch,ALUOp}.
  function automatic logic [CTRL_W-1:0] decode_ctrl(input state_t s);
    logic [1:0] src_a, src_b, res_src, alu_op;
    logic       adr, irw, rw, mw, pcu, br;
    src_a = 2'b00; src_b = 2'b00; res_src = 2'b00; alu_op = 2'b00;
    adr = 1'b0; irw = 1'b0; rw = 1'b0; mw = 1'b0; pcu = 1'b0; br = 1'b0;
    case (s)
      S_FETCH: begin
        irw = 1'b1; src_b = 2'b10; res_src = 2'b10; pcu = 1'b1;
      end
      S_DECODE:   begin src_a = 2'b01; src_b = 2'b01; end
      S_MEMADR:   begin src_a = 2'b10; src_b = 2'b01; end
      S_MEMREAD:  adr = 1'b1;
      S_MEMWB:    begin res_src = 2'b01; rw = 1'b1; end
      S_MEMWRITE: begin adr = 1'b1; mw = 1'b1; end
      S_EXECR:    begin src_a = 2'b10; alu_op = 2'b10; end
      S_EXECI:    begin src_a = 2'b10; src_b = 2'b01; alu_op = 2'b10; end
      S_ALUWB:    rw = 1'b1;
      S_JAL:      begin src_a = 2'b01; src_b = 2'b10; pcu = 1'b1; end
      S_BEQ:      begin src_a = 2'b10; alu_op = 2'b01; br = 1'b1; end
      default:    ;
    endcase
    return {src_a, src_b, res_src, adr, irw, rw, mw, pcu, br, alu_op};
  endfunction

  // State and control register; control is decoded from the state being entered
  // so it lines up with the state register on every edge and on reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      ctrl_q  <= decode_ctrl(S_FETCH);
    end else begin
      state_q <= next_state(state_q, op);
      ctrl_q  <= decode_ctrl(next_state(state_q, op));
    end
  end

  // Unused encodings present all-zero controls until they fall back to Fetch.
  assign state_legal = (4'(state_q) <= 4'(S_BEQ));
  assign ctrl        = state_legal ? ctrl_q : '0;

  assign {ALUSrcA, ALUSrcB, ResultSrc, AdrSrc, IRWrite, RegWrite,
          MemWrite, PCUpdate, Branch, ALUOp} = ctrl;

  assign PCWrite = PCUpdate | (Branch & Zero);
  assign state   = 4'(state_q);

endmodule

// File: tb/tb_main_fsm.sv
// Scoreboard bench for main_fsm: per-instruction state sequences from opcode
// latency rules, per-state outputs from the control table.
module tb_main_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic       Zero;
  logic [1:0] ALUSrcA, ALUSrcB, ResultSrc, ALUOp;
  logic       AdrSrc, IRWrite, RegWrite, MemWrite, PCUpdate, Branch, PCWrite;
  logic [3:0] state;

  typedef struct packed {
    logic [3:0]  st;
    logic [13:0] ctrl;
    logic        pcw;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  main_fsm dut (
    .clk(clk), .reset(reset), .op(op), .Zero(Zero),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
    .AdrSrc(AdrSrc), .IRWrite(IRWrite), .RegWrite(RegWrite),
    .MemWrite(MemWrite), .PCUpdate(PCUpdate), .Branch(Branch),
    .PCWrite(PCWrite), .ALUOp(ALUOp), .state(state)
  );

  always #5 clk = ~clk;

  // Expected controls per state name, straight from the output table.
  function automatic exp_t ref_out(input int s, input logic z);
    logic [1:0] a, b, r, alu;
    logic adr, ir, rw, mw, pcu, br;
    exp_t e;
    a = 0; b = 0; r = 0; alu = 0; adr = 0; ir = 0; rw = 0; mw = 0; pcu = 0; br = 0;
    case (s)
      0:  begin adr = 0; ir = 1; a = 2'b00; b = 2'b10; alu = 2'b00; r = 2'b10; pcu = 1; end
      1:  begin a = 2'b01; b = 2'b01; end
      2:  begin a = 2'b10; b = 2'b01; end
      3:  begin r = 2'b00; adr = 1; end
      4:  begin r = 2'b01; rw = 1; end
      5:  begin adr = 1; mw = 1; end
      6:  begin a = 2'b10; b = 2'b00; alu = 2'b10; end
      7:  begin rw = 1; end
      8:  begin a = 2'b10; b = 2'b01; alu = 2'b10; end
      9:  begin a = 2'b01; b = 2'b10; pcu = 1; end
      10: begin a = 2'b10; alu = 2'b01; br = 1; end
      default: ;
    endcase
    e.st   = 4'(s);
    e.ctrl = {a, b, r, adr, ir, rw, mw, pcu, br, alu};
    e.pcw  = pcu | (br & z);
    return e;
  endfunction

  // Visited states for one instruction, from the per-opcode latency rules.
  function automatic void push_instr(input logic [6:0] o, input logic z);
    int seq[$];
    case (o)
      7'b0000011: seq = '{0, 1, 2, 3, 4};
      7'b0100011: seq = '{0, 1, 2, 5};
      7'b0110011: seq = '{0, 1, 6, 7};
      7'b0010011: seq = '{0, 1, 8, 7};
      7'b1101111: seq = '{0, 1, 9, 7};
      7'b1100011: seq = '{0, 1, 10};
      default:    seq = '{0, 1};
    endcase
    foreach (seq[i]) exp_q.push_back(ref_out(seq[i], z));
  endfunction

  function automatic int instr_len(input logic [6:0] o);
    case (o)
      7'b0000011: return 5;
      7'b0100011, 7'b0110011, 7'b0010011, 7'b1101111: return 4;
      7'b1100011: return 3;
      default:    return 2;
    endcase
  endfunction

  task automatic check(input string name, input exp_t e);
    exp_t act;
    act.st   = state;
    act.ctrl = {ALUSrcA, ALUSrcB, ResultSrc, AdrSrc, IRWrite, RegWrite,
                MemWrite, PCUpdate, Branch, ALUOp};
    act.pcw  = PCWrite;
    n_cmp++;
    if (act !== e) begin
      n_fail++;
      $display("FAIL %s t=%0t: got state=%0d ctrl=%b pcw=%b, want state=%0d ctrl=%b pcw=%b",
               name, $time, act.st, act.ctrl, act.pcw, e.st, e.ctrl, e.pcw);
    end
  endtask

  // Monitor: one expected entry per cycle, sampled mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) check("cycle", exp_q.pop_front());
  end

  task automatic run_instr(input logic [6:0] o, input logic z);
    op   = o;
    Zero = z;
    push_instr(o, z);
    repeat (instr_len(o)) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [6:0] ops[7];
    logic [6:0] r;
    ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
            7'b1101111, 7'b1100011, 7'b0000000};
    reset = 1'b1;
    op    = 7'b0;
    Zero  = 1'b0;
    #1 check("reset_hold", ref_out(0, 1'b0));
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Directed instruction mix
    run_instr(7'b0000011, 1'b0);
    run_instr(7'b0100011, 1'b1);
    run_instr(7'b0110011, 1'b0);
    run_instr(7'b0010011, 1'b1);
    run_instr(7'b1100011, 1'b1);
    run_instr(7'b1100011, 1'b0);
    run_instr(7'b1101111, 1'b0);
    run_instr(7'b0000000, 1'b1);

    // Asynchronous reset while in MemRead
    op   = 7'b0000011;
    Zero = 1'b0;
    exp_q.push_back(ref_out(0, 1'b0));
    exp_q.push_back(ref_out(1, 1'b0));
    exp_q.push_back(ref_out(2, 1'b0));
    exp_q.push_back(ref_out(3, 1'b0));
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1 reset = 1'b1;
    #1 check("async_reset", ref_out(0, 1'b0));
    exp_q.push_back(ref_out(0, 1'b0));
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    run_instr(7'b0000011, 1'b1);

    // Randomized instruction stream, including arbitrary unsupported opcodes
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 7) == 0) r = 7'($urandom);
      else r = ops[$urandom_range(0, 6)];
      run_instr(r, 1'($urandom));
    end

    @(negedge clk);
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending entries, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish by %0t, want finish", $time);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/main_fsm.md
MAIN_FSM -- requirements
Module: main_fsm

Interface
REQ-001 The block SHALL have no parameters.
REQ-002 clk  input  1  sole clock; all state changes occur on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 op  input  7  opcode field of the instruction register, instr[6:0].
REQ-005 Zero  input  1  ALU zero flag, sampled combinationally in BEQ.
REQ-006 ALUSrcA  output  2  00=PC, 01=OldPC, 10=register A.
REQ-007 ALUSrcB  output  2  00=register B, 01=ImmExt, 10=constant 4.
REQ-008 ResultSrc  output  2  00=ALUOut, 01=Data (memory data register), 10=ALUResult.
REQ-009 AdrSrc  output  1  memory address select: 0=PC, 1=Result.
REQ-010 IRWrite, RegWrite, MemWrite, PCUpdate, Branch  output  1 each  write/update strobes.
REQ-011 PCWrite  output  1  PCUpdate OR (Branch AND Zero).
REQ-012 ALUOp  output  2  to the ALU decoder: 00=add, 01=subtract, 10=decode from funct3/funct7.
REQ-013 state  output  4  current state encoding, for debug and bench checking.

Function
REQ-014 The block SHALL be a Moore FSM: every output except PCWrite SHALL be a pure function of the registered state.
REQ-015 The state encodings SHALL be: Fetch=0, Decode=1, MemAdr=2, MemRead=3, MemWB=4, MemWrite=5, ExecuteR=6, ALUWB=7, ExecuteI=8, JAL=9, BEQ=10.
REQ-016 Any output field not listed for a state SHALL be 0.
REQ-017 Fetch outputs SHALL be: AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10, PCUpdate=1.
REQ-018 Decode outputs SHALL be: ALUSrcA=01, ALUSrcB=01, ALUOp=00.
REQ-019 MemAdr outputs SHALL be: ALUSrcA=10, ALUSrcB=01, ALUOp=00.
REQ-020 MemRead outputs SHALL be: ResultSrc=00, AdrSrc=1.
REQ-021 MemWB outputs SHALL be: ResultSrc=01, RegWrite=1.
REQ-022 MemWrite-state outputs SHALL be: ResultSrc=00, AdrSrc=1, MemWrite=1.
REQ-023 ExecuteR outputs SHALL be: ALUSrcA=10, ALUSrcB=00, ALUOp=10.
REQ-024 ExecuteI outputs SHALL be: ALUSrcA=10, ALUSrcB=01, ALUOp=10.
REQ-025 ALUWB outputs SHALL be: ResultSrc=00, RegWrite=1.
REQ-026 JAL outputs SHALL be: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1.
REQ-027 BEQ outputs SHALL be: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1.
REQ-028 Transitions SHALL be:
- Fetch->Decode.
- Decode->MemAdr when op=0000011 or 0100011.
- Decode->ExecuteR when op=0110011.
- Decode->ExecuteI when op=0010011.
- Decode->JAL when op=1101111.
- Decode->BEQ when op=1100011.
- Decode->Fetch for any other opcode.
REQ-029 MemAdr SHALL go to MemRead when op=0000011, to MemWrite when op=0100011, and to Fetch otherwise.
REQ-030 Remaining transitions SHALL be:
- MemRead->MemWB->Fetch.
- MemWrite->Fetch.
- ExecuteR, ExecuteI and JAL->ALUWB.
- ALUWB->Fetch.
- BEQ->Fetch.
REQ-031 Unused encodings 11-15 SHALL go to Fetch on the next edge, with all outputs 0 while held.
REQ-032 Instruction latency SHALL be: lw 5 cycles; sw, R-type, I-type and jal 4 cycles; beq 3 cycles; unsupported opcode 2 cycles.
REQ-033 PCWrite SHALL follow Zero combinationally in BEQ and SHALL be 0 in BEQ when Zero=0.

Reset
REQ-034 Asserting reset SHALL force state=Fetch immediately, independent of clk, including mid-instruction.
REQ-035 While reset is high, outputs SHALL equal the Fetch values, with PCWrite=1.
REQ-036 After reset deasserts, the first rising edge SHALL move the FSM to Decode.

Verification
REQ-037 Reset, then op=0000011 for 5 cycles -> state 0,1,2,3,4,0; RegWrite=1 only in state 4; AdrSrc=1 in state 3.
REQ-038 op=0100011 -> state 0,1,2,5,0; MemWrite=1 for exactly one cycle.
REQ-039 op=0110011, then op=0010011 -> ALUOp=10 in states 6 and 8 respectively, each followed by state 7 with RegWrite=1.
REQ-040 op=1100011 with Zero=1, then with Zero=0 -> PCWrite=1 then 0 in state 10; ALUOp=01 both times.
REQ-041 op=1101111 -> state 0,1,9,7,0; PCWrite=1 in state 9; op=0000000 -> state 0,1,0.
REQ-042 Assert reset asynchronously in MemRead (state 3) -> state=0 before the next clk edge; Fetch outputs present.
